// File: rtl/e203_icb_pkg.sv
// ============================================================================
// e203_icb_pkg : ICB size encodings and response/stage-1 payload types
// Rev 1.0
// ============================================================================
`default_nettype none

package e203_icb_pkg;

    localparam logic [1:0] ICB_SIZE_B = 2'd0;
    localparam logic [1:0] ICB_SIZE_H = 2'd1;
    localparam logic [1:0] ICB_SIZE_W = 2'd2;

    typedef struct packed {
        logic        err;
        logic        excl_ok;
        logic [31:0] rdata;
    } icb_rsp_t;

    typedef struct packed {
        logic vld;
        logic err;
        logic excl_ok;
        logic is_read;
    } icb_s1_t;

endpackage

`default_nettype wire

// File: rtl/e203_icb_rsp_fifo.sv
// ============================================================================
// e203_icb_rsp_fifo : 2-entry in-order fall-through FIFO for ICB responses
// Rev 1.0
// ============================================================================
`default_nettype none

module e203_icb_rsp_fifo
    import e203_icb_pkg::*;
#(
    parameter type T = icb_rsp_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_vld,
    output logic i_rdy,
    input  T     i_dat,
    output logic o_vld,
    input  logic o_rdy,
    output T     o_dat
);

    T           r_mem [0:1];
    logic       r_wptr;
    logic       r_rptr;
    logic [1:0] r_cnt;

    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_cnt == 2'd0);
    assign i_rdy   = (r_cnt != 2'd2);
    // An input consumed straight through an empty FIFO is never stored.
    assign w_push  = i_vld && i_rdy && !(w_empty && o_rdy);
    assign w_pop   = o_rdy && !w_empty;

    assign o_vld = !w_empty || i_vld;
    assign o_dat = w_empty ? i_dat : r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_cnt  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

`default_nettype wire

// File: rtl/e203_icb_sram_rsp.sv
// ============================================================================
// e203_icb_sram_rsp : ICB responder onto a 1-cycle synchronous SRAM with
//                     bounds/alignment checking and an LR/SC reservation
// Rev 1.0
// ============================================================================
`default_nettype none

module e203_icb_sram_rsp
    import e203_icb_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_icb_cmd_valid,
    output logic          o_icb_cmd_ready,
    input  logic [31:0]   i_icb_cmd_addr,
    input  logic          i_icb_cmd_read,
    input  logic [31:0]   i_icb_cmd_wdata,
    input  logic [3:0]    i_icb_cmd_wmask,
    input  logic          i_icb_cmd_lock,
    input  logic          i_icb_cmd_excl,
    input  logic [1:0]    i_icb_cmd_size,
    output logic          o_icb_rsp_valid,
    input  logic          i_icb_rsp_ready,
    output logic          o_icb_rsp_err,
    output logic          o_icb_rsp_excl_ok,
    output logic [31:0]   o_icb_rsp_rdata,
    output logic          o_ram_cs,
    output logic          o_ram_we,
    output logic [AW-3:0] o_ram_addr,
    output logic [3:0]    o_ram_wem,
    output logic [31:0]   o_ram_din,
    input  logic [31:0]   i_ram_dout,
    output logic          o_idle
);

    logic [1:0]    r_cnt;
    logic          r_rsv_vld;
    logic [AW-3:0] r_rsv_addr;
    icb_s1_t       r_s1;

    logic          w_cmd_hsk;
    logic          w_rsp_hsk;
    logic          w_err;
    logic [AW-3:0] w_word;
    logic          w_rsv_hit;
    logic          w_sc_fail;
    logic          w_ram_go;
    logic          w_wr_go;
    logic          w_excl_ok;
    icb_rsp_t      w_s1_rsp;
    icb_rsp_t      w_rsp;
    logic          w_fifo_in_rdy;
    logic          w_unused;

    assign w_unused = i_icb_cmd_lock | w_fifo_in_rdy;

    assign o_icb_cmd_ready = (r_cnt < 2'd2);
    assign w_cmd_hsk       = i_icb_cmd_valid && o_icb_cmd_ready;
    assign w_rsp_hsk       = o_icb_rsp_valid && i_icb_rsp_ready;

    assign w_err = ((i_icb_cmd_addr >> AW) != 32'd0)
                || (i_icb_cmd_size == 2'd3)
                || ((i_icb_cmd_size == ICB_SIZE_H) && i_icb_cmd_addr[0])
                || ((i_icb_cmd_size == ICB_SIZE_W) && (i_icb_cmd_addr[1:0] != 2'd0));

    assign w_word    = i_icb_cmd_addr[AW-1:2];
    assign w_rsv_hit = r_rsv_vld && (r_rsv_addr == w_word);
    assign w_sc_fail = !i_icb_cmd_read && i_icb_cmd_excl && !w_rsv_hit;
    assign w_excl_ok = !w_err && i_icb_cmd_excl && (i_icb_cmd_read || w_rsv_hit);

    // rst_n gate keeps the macro quiet while reset holds the counter at zero.
    assign w_ram_go = w_cmd_hsk && !w_err && !w_sc_fail && rst_n;
    assign w_wr_go  = w_ram_go && !i_icb_cmd_read;

    assign o_ram_cs   = w_ram_go;
    assign o_ram_we   = w_wr_go;
    assign o_ram_wem  = w_wr_go ? i_icb_cmd_wmask : 4'b0000;
    assign o_ram_addr = w_word;
    assign o_ram_din  = i_icb_cmd_wdata;

    assign o_idle = (r_cnt == 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 2'd0;
        end else begin
            r_cnt <= r_cnt + {1'b0, w_cmd_hsk} - {1'b0, w_rsp_hsk};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsv_vld  <= 1'b0;
            r_rsv_addr <= '0;
        end else if (w_cmd_hsk) begin
            if (i_icb_cmd_read && i_icb_cmd_excl && !w_err) begin
                r_rsv_vld  <= 1'b1;
                r_rsv_addr <= w_word;
            end else if (!i_icb_cmd_read && i_icb_cmd_excl) begin
                r_rsv_vld <= 1'b0;
            end else if (!i_icb_cmd_read && !w_err && (w_word == r_rsv_addr)) begin
                r_rsv_vld <= 1'b0;
            end
        end
    end

    // Stage-1 fields are zeroed when idle so the response bus rests at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
        end else if (w_cmd_hsk) begin
            r_s1.vld     <= 1'b1;
            r_s1.err     <= w_err;
            r_s1.excl_ok <= w_excl_ok;
            r_s1.is_read <= i_icb_cmd_read;
        end else begin
            r_s1 <= '0;
        end
    end

    assign w_s1_rsp.err     = r_s1.err;
    assign w_s1_rsp.excl_ok = r_s1.excl_ok;
    assign w_s1_rsp.rdata   = (r_s1.is_read && !r_s1.err) ? i_ram_dout : 32'd0;

    e203_icb_rsp_fifo #(
        .T (icb_rsp_t)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .i_vld (r_s1.vld),
        .i_rdy (w_fifo_in_rdy),
        .i_dat (w_s1_rsp),
        .o_vld (o_icb_rsp_valid),
        .o_rdy (i_icb_rsp_ready),
        .o_dat (w_rsp)
    );

    assign o_icb_rsp_err     = w_rsp.err;
    assign o_icb_rsp_excl_ok = w_rsp.excl_ok;
    assign o_icb_rsp_rdata   = w_rsp.rdata;

endmodule

`default_nettype wire

// File: tb/tb_e203_icb_sram_rsp.sv
// ============================================================================
// tb_e203_icb_sram_rsp : table-driven + scoreboard bench for e203_icb_sram_rsp
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_e203_icb_sram_rsp;
    import e203_icb_pkg::*;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [31:0]   cmd_addr = '0;
    logic          cmd_read = 1'b0;
    logic [31:0]   cmd_wdata = '0;
    logic [3:0]    cmd_wmask = '0;
    logic          cmd_lock = 1'b0;
    logic          cmd_excl = 1'b0;
    logic [1:0]    cmd_size = 2'd2;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic          rsp_err;
    logic          rsp_excl_ok;
    logic [31:0]   rsp_rdata;
    logic          ram_cs;
    logic          ram_we;
    logic [AW-3:0] ram_addr;
    logic [3:0]    ram_wem;
    logic [31:0]   ram_din;
    logic [31:0]   ram_dout = '0;
    logic          idle;

    always #5 clk = ~clk;

    e203_icb_sram_rsp #(.AW(AW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_icb_cmd_valid   (cmd_valid),
        .o_icb_cmd_ready   (cmd_ready),
        .i_icb_cmd_addr    (cmd_addr),
        .i_icb_cmd_read    (cmd_read),
        .i_icb_cmd_wdata   (cmd_wdata),
        .i_icb_cmd_wmask   (cmd_wmask),
        .i_icb_cmd_lock    (cmd_lock),
        .i_icb_cmd_excl    (cmd_excl),
        .i_icb_cmd_size    (cmd_size),
        .o_icb_rsp_valid   (rsp_valid),
        .i_icb_rsp_ready   (rsp_ready),
        .o_icb_rsp_err     (rsp_err),
        .o_icb_rsp_excl_ok (rsp_excl_ok),
        .o_icb_rsp_rdata   (rsp_rdata),
        .o_ram_cs          (ram_cs),
        .o_ram_we          (ram_we),
        .o_ram_addr        (ram_addr),
        .o_ram_wem         (ram_wem),
        .o_ram_din         (ram_din),
        .i_ram_dout        (ram_dout),
        .o_idle            (idle)
    );

    // Behavioural single-port SRAM with 1-cycle read latency
    logic [31:0] mem [0:(1<<(AW-2))-1];
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_wem[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
            end else begin
                ram_dout <= mem[ram_addr];
            end
        end
    end

    typedef struct packed {
        logic        err;
        logic        ok;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        logic        rd;
        logic        ex;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wm;
        logic        err;
        logic        ok;
        logic [31:0] rdata;
        logic        cs;
    } vec_t;

    exp_t sb[$];
    vec_t vt[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic vec_t mk(input logic rd, input logic ex, input logic [1:0] sz,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] wm, input logic err, input logic ok,
                                input logic [31:0] rdata, input logic cs);
        vec_t v;
        v.rd = rd; v.ex = ex; v.sz = sz; v.addr = addr; v.wdata = wdata; v.wm = wm;
        v.err = err; v.ok = ok; v.rdata = rdata; v.cs = cs;
        return v;
    endfunction

    function automatic exp_t to_exp(input vec_t v);
        exp_t e;
        e.err = v.err; e.ok = v.ok; e.rdata = v.rdata;
        return e;
    endfunction

    task automatic drive(input vec_t v);
        cmd_valid = 1'b1; cmd_read = v.rd; cmd_excl = v.ex; cmd_size = v.sz;
        cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wmask = v.wm;
    endtask

    // Presents one command, waits (bounded) for acceptance, then pushes its expectation.
    task automatic send(input vec_t v);
        int guard;
        guard = 0;
        drive(v);
        @(negedge clk);
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) begin
            check("cmd_accept_timeout", 32'd0, 32'd1);
        end else begin
            check("ram_cs_on_accept", {31'd0, ram_cs}, {31'd0, v.cs});
            sb.push_back(to_exp(v));
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Scoreboard consumer
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                check("rsp_excl_ok", {31'd0, rsp_excl_ok}, {31'd0, e.ok});
                check("rsp_rdata", rsp_rdata, e.rdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] bp_addr [0:3];
    logic [31:0] bp_data [0:3];

    initial begin
        int k;
        int it;
        logic [31:0] held;
        vec_t v;

        // ---------------- reset state (legal read held during reset) ----------------
        v = mk(1, 0, 2'd2, 32'h10, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 drive(v);
        @(negedge clk);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_idle", {31'd0, idle}, 32'd1);
        check("rst_ram_cs", {31'd0, ram_cs}, 32'd0);
        check("rst_ram_we", {31'd0, ram_we}, 32'd0);
        check("rst_ram_wem", {28'd0, ram_wem}, 32'd0);
        check("rst_rsp_payload", {rsp_err, rsp_excl_ok, rsp_rdata[29:0]}, 32'd0);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // ---------------- table-driven vectors, rsp_ready held high ----------------
        //                rd ex sz    addr           wdata          wm       err ok rdata          cs
        vt.push_back(mk(0, 0, 2'd2, 32'h0000_0010, 32'hDEADBEEF, 4'b1111, 0, 0, 32'h0,        1));
        vt.push_back(mk(1, 0, 2'd2, 32'h0000_0010, 32'h0,        4'b0000, 0, 0, 32'hDEADBEEF, 1));
        vt.push_back(mk(0, 0, 2'd2, 32'h0000_0020, 32'h11223344, 4'b1111, 0, 0, 32'h0,        1));
        vt.push_back(mk(0, 0, 2'd0, 32'h0000_0020, 32'h000000AA, 4'b0001, 0, 0, 32'h0,        1));
        vt.push_back(mk(1, 0, 2'd2, 32'h0000_0020, 32'h0,        4'b0000, 0, 0, 32'h112233AA, 1));
        vt.push_back(mk(1, 0, 2'd2, 32'h0001_0000, 32'h0,        4'b0000, 1, 0, 32'h0,        0));
        vt.push_back(mk(1, 0, 2'd1, 32'h0000_0003, 32'h0,        4'b0000, 1, 0, 32'h0,        0));
        vt.push_back(mk(0, 0, 2'd2, 32'h0000_0040, 32'h0,        4'b1111, 0, 0, 32'h0,        1));
        vt.push_back(mk(1, 1, 2'd2, 32'h0000_0040, 32'h0,        4'b0000, 0, 1, 32'h0,        1));
        vt.push_back(mk(0, 1, 2'd2, 32'h0000_0040, 32'h5,        4'b1111, 0, 1, 32'h0,        1));
        vt.push_back(mk(1, 0, 2'd2, 32'h0000_0040, 32'h0,        4'b0000, 0, 0, 32'h5,        1));
        vt.push_back(mk(0, 1, 2'd2, 32'h0000_0040, 32'h9,        4'b1111, 0, 0, 32'h0,        0));
        vt.push_back(mk(1, 0, 2'd2, 32'h0000_0040, 32'h0,        4'b0000, 0, 0, 32'h5,        1));
        vt.push_back(mk(1, 1, 2'd2, 32'h0000_0040, 32'h0,        4'b0000, 0, 1, 32'h5,        1));
        vt.push_back(mk(0, 0, 2'd2, 32'h0000_0040, 32'h7,        4'b1111, 0, 0, 32'h0,        1));
        vt.push_back(mk(0, 1, 2'd2, 32'h0000_0040, 32'h8,        4'b1111, 0, 0, 32'h0,        0));
        vt.push_back(mk(1, 0, 2'd2, 32'h0000_0040, 32'h0,        4'b0000, 0, 0, 32'h7,        1));
        vt.push_back(mk(1, 1, 2'd2, 32'h0000_0040, 32'h0,        4'b0000, 0, 1, 32'h7,        1));
        vt.push_back(mk(0, 0, 2'd2, 32'h0000_0080, 32'h3,        4'b1111, 0, 0, 32'h0,        1));
        vt.push_back(mk(0, 1, 2'd2, 32'h0000_0040, 32'hA,        4'b1111, 0, 1, 32'h0,        1));
        vt.push_back(mk(1, 0, 2'd2, 32'h0000_0040, 32'h0,        4'b0000, 0, 0, 32'hA,        1));
        vt.push_back(mk(1, 0, 2'd3, 32'h0000_0000, 32'h0,        4'b0000, 1, 0, 32'h0,        0));
        vt.push_back(mk(1, 0, 2'd2, 32'h0000_0002, 32'h0,        4'b0000, 1, 0, 32'h0,        0));
        vt.push_back(mk(1, 0, 2'd1, 32'h0000_0012, 32'h0,        4'b0000, 0, 0, 32'hDEADBEEF, 1));
        vt.push_back(mk(0, 0, 2'd0, 32'h0000_0023, 32'hAA000000, 4'b1000, 0, 0, 32'h0,        1));
        vt.push_back(mk(1, 0, 2'd2, 32'h0000_0020, 32'h0,        4'b0000, 0, 0, 32'hAA2233AA, 1));

        for (int i = 0; i < vt.size(); i++) send(vt[i]);
        repeat (3) @(posedge clk);
        #1;

        // ---------------- latency: response valid the cycle after acceptance ----------------
        v = mk(1, 0, 2'd2, 32'h10, 0, 0, 0, 0, 32'hDEADBEEF, 1);
        drive(v);
        @(negedge clk);
        check("lat_idle_before", {31'd0, rsp_valid}, 32'd0);
        sb.push_back(to_exp(v));
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("lat_rsp_valid_t1", {31'd0, rsp_valid}, 32'd1);
        repeat (2) @(posedge clk);
        #1;

        // ---------------- backpressure: 4 reads with rsp_ready low ----------------
        bp_addr[0] = 32'h10; bp_data[0] = 32'hDEADBEEF;
        bp_addr[1] = 32'h20; bp_data[1] = 32'hAA2233AA;
        bp_addr[2] = 32'h40; bp_data[2] = 32'h0000000A;
        bp_addr[3] = 32'h80; bp_data[3] = 32'h00000003;
        rsp_ready = 1'b0;
        k = 0;
        drive(mk(1, 0, 2'd2, bp_addr[0], 0, 0, 0, 0, 0, 0));
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (cmd_valid && cmd_ready) begin
                sb.push_back('{err: 1'b0, ok: 1'b0, rdata: bp_data[k]});
                k++;
            end
            if (c == 2) held = rsp_rdata;
            @(posedge clk);
            #1;
            if (k < 4) cmd_addr = bp_addr[k];
            else cmd_valid = 1'b0;
        end
        @(negedge clk);
        check("bp_accepted", k, 32'd2);
        check("bp_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
        check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("bp_hold_stable", rsp_rdata, held);
        check("bp_head_data", rsp_rdata, 32'hDEADBEEF);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        it = 0;
        while ((k < 4 || sb.size() != 0) && it < 40) begin
            @(negedge clk);
            if (it == 0) check("bp_ready_still_low", {31'd0, cmd_ready}, 32'd0);
            if (it == 1) check("bp_ready_rise", {31'd0, cmd_ready}, 32'd1);
            if (cmd_valid && cmd_ready) begin
                sb.push_back('{err: 1'b0, ok: 1'b0, rdata: bp_data[k]});
                k++;
            end
            @(posedge clk);
            #1;
            if (k < 4) cmd_addr = bp_addr[k];
            else cmd_valid = 1'b0;
            it++;
        end
        check("bp_drain_done", {31'd0, (k == 4 && sb.size() == 0)}, 32'd1);
        @(negedge clk);
        check("bp_idle_end", {31'd0, idle}, 32'd1);
        @(posedge clk);
        #1;

        // ---------------- reset mid-operation ----------------
        send(mk(1, 1, 2'd2, 32'h40, 0, 0, 0, 1, 32'hA, 1));
        repeat (2) @(posedge clk);
        #1 rsp_ready = 1'b0;
        k = 0;
        drive(mk(1, 0, 2'd2, 32'h10, 0, 0, 0, 0, 0, 0));
        it = 0;
        while (k < 2 && it < 20) begin
            @(negedge clk);
            if (cmd_ready) k++;
            @(posedge clk);
            #1;
            it++;
        end
        check("rst_mid_outstanding", k, 32'd2);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_mid_ram_cs", {31'd0, ram_cs}, 32'd0);
        check("rst_mid_idle", {31'd0, idle}, 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        // Reservation must not survive reset
        send(mk(0, 1, 2'd2, 32'h40, 32'h55, 4'b1111, 0, 0, 32'h0, 0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("final_sb_empty", sb.size(), 32'd0);
        check("final_idle", {31'd0, idle}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
